// File: rtl/bf_pkg.sv
// Shared byte type and EOF byte value for the BF core input path.
package bf_pkg;
    typedef logic [7:0] byte_t;
    localparam byte_t BF_EOF_BYTE = 8'h00;
endpackage

// File: rtl/bf_fifo_mem.sv
// DEPTH x 8 register storage: one synchronous write port, one asynchronous read port, no reset.
module bf_fifo_mem
    import bf_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);
    byte_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bf_in_fifo.sv
// FWFT host-to-core input byte buffer. Optional sticky end-of-stream handling under macro
// BF_IN_EOF_EN: once EOF is seen and the buffer drains, the core reads 8'h00 forever.
module bf_in_fifo
    import bf_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  byte_t           wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic            eof,
    input  logic            flush,
    output byte_t           in,
    output logic            in_valid,
    input  logic            in_reading,
    output logic [ADDR_W:0] count
);
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            full, empty, push, pop, eof_seen;
    byte_t           rdata;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    // Registered state only: a full buffer refuses input even while the core pops it.
    assign wr_ready = !full && !flush && !eof_seen;
    assign push     = wr_valid && wr_ready;
    assign pop      = in_reading && in_valid && !empty;
    assign count    = wr_ptr - rd_ptr;

    assign in       = empty ? BF_EOF_BYTE : rdata;
    assign in_valid = !empty || eof_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef BF_IN_EOF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     eof_seen <= 1'b0;
        else if (flush) eof_seen <= 1'b0;
        else if (eof)   eof_seen <= 1'b1;
    end
`else
    assign eof_seen = 1'b0;
    logic eof_unused;
    assign eof_unused = eof;
`endif

    bf_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_bf_in_fifo.sv
// Scoreboard bench for bf_in_fifo; honours BF_IN_EOF_EN when the same macro is given to the build.
module tb_bf_in_fifo;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       eof = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] in;
    logic       in_valid;
    logic       in_reading = 1'b0;
    logic [4:0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q[$];
    bit eof_m = 1'b0;

    bf_in_fifo #(.DEPTH(16)) dut (
        .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .eof(eof), .flush(flush), .in(in), .in_valid(in_valid),
        .in_reading(in_reading), .count(count)
    );

    always #5 clock = ~clock;

    // Drive one cycle of stimulus, check all outputs against the model, then advance one edge.
    task automatic cycle(input string nm, input bit wv, input logic [7:0] wd, input bit rd,
                         input bit fl, input bit ev);
        bit         exp_rdy, exp_vld;
        logic [7:0] exp_in;
        wr_valid = wv; wr_data = wd; in_reading = rd; flush = fl; eof = ev;
        #1;
        exp_rdy = (q.size() < 16) && !fl && !eof_m;
        exp_vld = (q.size() > 0) || eof_m;
        exp_in  = (q.size() > 0) ? q[0] : 8'h00;
        n_cmp += 4;
        if (wr_ready !== exp_rdy) begin
            n_err++; $display("FAIL %s wr_ready: got %b expected %b", nm, wr_ready, exp_rdy);
        end
        if (in_valid !== exp_vld) begin
            n_err++; $display("FAIL %s in_valid: got %b expected %b", nm, in_valid, exp_vld);
        end
        if (in !== exp_in) begin
            n_err++; $display("FAIL %s in: got %h expected %h", nm, in, exp_in);
        end
        if (count !== 5'(q.size())) begin
            n_err++; $display("FAIL %s count: got %0d expected %0d", nm, count, q.size());
        end
        @(posedge clock);
        if (fl) begin
            q.delete();
            eof_m = 1'b0;
        end else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            if (wv && exp_rdy) q.push_back(wd);
`ifdef BF_IN_EOF_EN
            if (ev) eof_m = 1'b1;
`endif
        end
        #1;
        wr_valid = 1'b0; in_reading = 1'b0; flush = 1'b0; eof = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        n_cmp += 3;
        if (count !== 5'd0) begin n_err++; $display("FAIL %s count: got %0d expected 0", nm, count); end
        if (in_valid !== 1'b0) begin n_err++; $display("FAIL %s in_valid: got %b expected 0", nm, in_valid); end
        if (in !== 8'h00) begin n_err++; $display("FAIL %s in: got %h expected 00", nm, in); end
    endtask

    task automatic test_reset();
        #2 check_reset_outputs("reset_held");
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        cycle("reset_idle", 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_basic();
        cycle("basic_push", 1, 8'h41, 0, 0, 0);
        cycle("basic_push", 1, 8'h42, 0, 0, 0);
        cycle("basic_push", 1, 8'h43, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("basic_pop", 0, 8'h00, 1, 0, 0);
        cycle("basic_empty", 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) cycle("full_fill", 1, 8'(i), 0, 0, 0);
        cycle("full_drop", 1, 8'hFF, 0, 0, 0);
        cycle("full_pop_push", 1, 8'hFE, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle("full_drain", 0, 8'h00, 1, 0, 0);
        cycle("full_empty", 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cycle("b2b_fill", 1, 8'h60 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle("b2b_pushpop", 1, 8'h80 + 8'(i), 1, 0, 0);
    endtask

    task automatic test_empty_read();
        cycle("er_flush", 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle("er_read_empty", 0, 8'h00, 1, 0, 0);
        cycle("er_push", 1, 8'h2C, 0, 0, 0);
        cycle("er_head", 0, 8'h00, 1, 0, 0);
        cycle("er_after", 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 7; i++) cycle("fl_fill", 1, 8'hA0 + 8'(i), 0, 0, 0);
        cycle("fl_flush", 1, 8'hEE, 1, 1, 0);
        cycle("fl_after", 0, 8'h00, 0, 0, 0);
        cycle("rs_burst", 1, 8'h11, 0, 0, 0);
        cycle("rs_burst", 1, 8'h12, 0, 0, 0);
        wr_valid = 1'b1; wr_data = 8'h13;
        reset = 1'b0;
        #1 check_reset_outputs("rs_async");
        q.delete(); eof_m = 1'b0;
        wr_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        cycle("rs_after", 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_eof();
        cycle("eof_push", 1, 8'h31, 0, 0, 0);
        cycle("eof_raise", 0, 8'h00, 0, 0, 1);
        cycle("eof_refuse", 1, 8'h77, 0, 0, 0);
        cycle("eof_pop31", 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle("eof_pop0", 0, 8'h00, 1, 0, 0);
        cycle("eof_flush", 0, 8'h00, 0, 1, 0);
        cycle("eof_cleared", 1, 8'h55, 0, 0, 0);
        cycle("eof_final", 0, 8'h00, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_empty_read();
        test_flush_reset();
        test_eof();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
